// File: rtl/neural_packetizer_mc.sv
// Multichannel neural sample packetizer: per-channel raw/spike filtering, timestamped
// data words and periodic drop-count sync words, buffered in a FWFT valid/ready FIFO.
module neural_packetizer_mc #(
    parameter int unsigned SAMPLE_W   = 12,
    parameter int unsigned CH_W       = 4,
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned TS_W       = 12,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned OUT_W     = 4 + CH_W + TS_W + SAMPLE_W,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [SAMPLE_W-1:0] adc_sample,
    input  logic [CH_W-1:0]     adc_channel,
    input  logic                adc_valid,
    input  logic                mode,
    input  logic [SAMPLE_W-1:0] threshold,
    input  logic [NUM_CH-1:0]   ch_enable,
    output logic [OUT_W-1:0]    data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic [LVL_W-1:0]    fifo_level,
    output logic [15:0]         drop_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned DEV_W = SAMPLE_W + 1;
    localparam int unsigned CH_N  = 1 << CH_W;
    localparam logic [DEV_W-1:0] MID = DEV_W'(1) << (SAMPLE_W - 1);

    logic [TS_W-1:0]     ts;
    logic                sync_pending;
    logic                ovf_pending;

    logic                s1_keep;
    logic                s1_spike;
    logic [CH_W-1:0]     s1_ch;
    logic [TS_W-1:0]     s1_ts;
    logic [SAMPLE_W-1:0] s1_sample;

    logic [OUT_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    // Capture-side keep decision
    logic [DEV_W-1:0]    samp_ext;
    logic [DEV_W-1:0]    dev;
    logic [CH_N-1:0]     en_ext;
    logic                spike_c;
    logic                keep_c;

    always_comb begin
        samp_ext = {1'b0, adc_sample};
        dev      = (samp_ext >= MID) ? (samp_ext - MID) : (MID - samp_ext);
        spike_c  = dev > {1'b0, threshold};
        en_ext   = CH_N'(ch_enable);
        keep_c   = adc_valid && (32'(adc_channel) < NUM_CH) && en_ext[adc_channel]
                   && (!mode || spike_c);
    end

    // Write arbitration: data beats sync; the head register counts toward the level
    logic                pop;
    logic                can_wr;
    logic                data_wr;
    logic                sync_wr;
    logic                wr;
    logic                load;
    logic [LVL_W-1:0]    mem_cnt;
    logic [OUT_W-1:0]    wr_word;

    always_comb begin
        pop     = data_valid && data_ready;
        can_wr  = (32'(fifo_level) < FIFO_DEPTH) || pop;
        data_wr = s1_keep && can_wr;
        sync_wr = !s1_keep && sync_pending && can_wr;
        wr      = data_wr || sync_wr;
        mem_cnt = fifo_level - LVL_W'(data_valid);
        load    = (mem_cnt != '0) && (!data_valid || pop);
        if (data_wr) begin
            wr_word = {2'b01, ovf_pending, s1_spike, s1_ch, s1_ts, s1_sample};
        end else begin
            wr_word = {2'b10, 2'b00, (OUT_W - 4)'(drop_count)};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ts           <= '0;
            sync_pending <= 1'b0;
            ovf_pending  <= 1'b0;
            drop_count   <= '0;
            s1_keep      <= 1'b0;
            s1_spike     <= 1'b0;
            s1_ch        <= '0;
            s1_ts        <= '0;
            s1_sample    <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
        end else begin
            ts        <= ts + TS_W'(1);
            s1_keep   <= keep_c;
            s1_spike  <= spike_c;
            s1_ch     <= adc_channel;
            s1_ts     <= ts;
            s1_sample <= adc_sample;

            // A wrap on the same edge as a sync write re-arms for the new period
            if (ts == '1) begin
                sync_pending <= 1'b1;
            end else if (sync_wr) begin
                sync_pending <= 1'b0;
            end

            if (s1_keep && !can_wr) begin
                ovf_pending <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end else if (data_wr) begin
                ovf_pending <= 1'b0;
            end

            if (wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            fifo_level <= LVL_W'(fifo_level + LVL_W'(wr) - LVL_W'(pop));

            if (load) begin
                data_out   <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + PTR_W'(1);
                data_valid <= 1'b1;
            end else if (pop) begin
                data_valid <= 1'b0;
            end
        end
    end

    // Storage array; contents are don't-care after reset since the pointers restart
    always_ff @(posedge sys_clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_word;
        end
    end

endmodule

// File: doc/neural_packetizer_mc.md
Name: neural_packetizer_mc

Overview:
Parametrised multichannel successor to the single-path implant sample packer. It accepts ADC samples tagged with a channel number and filters them per channel, with a raw mode and a threshold spike mode. Each kept sample is packed with a timestamp into an output word and buffered in a FIFO behind a valid/ready output. Periodic sync words carry the drop count so downstream telemetry can detect loss.

Parameters:
SAMPLE_W, 12, ADC sample width, offset-binary.
CH_W, 4, channel index width.
NUM_CH, 16, number of channels; must be <= 2**CH_W.
TS_W, 12, free-running timestamp width.
FIFO_DEPTH, 16, output FIFO entries; power of two, >= 2.
OUT_W, 4+CH_W+TS_W+SAMPLE_W (32 at defaults), output word width; derived localparam, not overridable.

Ports:
sys_clk  in  1  single clock for the whole block.
sys_rst  in  1  synchronous, active-high reset.
adc_sample  in  SAMPLE_W  sample.
adc_channel  in  CH_W  channel of sample.
adc_valid  in  1  sample qualifier, one sample per cycle max.
mode  in  1  0 = raw (keep all), 1 = spike (keep only threshold crossings).
threshold  in  SAMPLE_W  spike threshold on deviation from midscale.
ch_enable  in  NUM_CH  per-channel enable mask.
data_out  out  OUT_W  FIFO head word.
data_valid  out  1  data_out valid.
data_ready  in  1  consumer accepts head when data_valid && data_ready.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
drop_count  out  16  saturating count of kept samples lost to FIFO full.

Behaviour:
- Reset (sys_rst=1 at posedge): data_valid=0, data_out=0, fifo_level=0, drop_count=0, timestamp=0, ovf_pending=0, sync_pending=0. FIFO contents are discarded. Reset mid-stream aborts everything, and no partial word is emitted.
- Timestamp ts: TS_W-bit counter, increments every cycle, wraps to 0.
- Stage 1 (capture), posedge N with adc_valid=1: register sample, channel and ts. Compute the keep decision from mode, threshold and ch_enable as sampled at edge N.
- Keep rule: channel >= NUM_CH, or ch_enable[channel]=0, means discard with no count. mode=0 means keep. mode=1 means keep iff dev > threshold (strict).
- dev = |sample - 2**(SAMPLE_W-1)|, computed in SAMPLE_W+1 bits. Examples: 0x800→0, 0x000→0x800, 0xFFF→0x7FF.
- Data word = {2'b01, ovf, spike, channel, ts, sample}, MSB first. spike = (dev > threshold), reported in both modes.
- Sync word = {2'b10, 2'b00, zero-extended drop_count}.
- sync_pending is set on the cycle ts wraps from all-ones to 0.
- Stage 2 (FIFO write), edge N+1:
  - A kept data word has priority over a sync word.
  - A sync word is written in the first cycle with no data write and a free slot; then sync_pending clears.
  - A second wrap while already pending is merged (one sync word only).
- Full handling:
  - A write is allowed if level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A kept data word that cannot be written: drop_count += 1 (saturates at 0xFFFF) and ovf_pending=1.
  - The next data word written carries ovf=1, then ovf_pending clears.
  - A sync word that cannot be written stays pending.
- Output: FIFO is first-word-fall-through.
  - data_valid = (level != 0), registered.
  - data_out holds stable while data_valid && !data_ready.
  - Latency with FIFO empty: sample at edge N → data_valid=1 after edge N+2.
- Simultaneous push and pop: level is unchanged and ordering is preserved.
- Ordering: FIFO order equals write order. Nothing is reordered or duplicated.

Test Plan:
- Raw mode, all channels enabled, data_ready=1: 20 consecutive samples on channels 0..15 → 20 words in order, tag 01, correct ch/ts/sample, first valid 2 cycles after first adc_valid.
- Spike mode, threshold=0x100: samples 0x800, 0x901, 0x900, 0x6FF on ch 3 → only 0x901 and 0x6FF emitted, spike=1.
- ch_enable=16'h0001: samples on ch 0 and ch 5 → only ch 0 emitted; drop_count stays 0.
- Backpressure with data_ready=0, FIFO_DEPTH=16:
  - 20 raw samples → level=16, drop_count=4.
  - Release ready and send one sample → 16 words out in order, then one word with ovf=1.
- Timestamp wrap: run 4096+ cycles with sparse samples → sync word tag 10 with the current drop_count appears. A sample arriving in the same cycle as the wrap is written first, and the sync word follows.
- Reset asserted with 5 words queued → next cycle data_valid=0, level=0, drop_count=0. Next sample is emitted with ts counted from 0.
